// File: rtl/tft_byte_fifo.sv
// -----------------------------------------------------------------------------
// tft_byte_fifo
//
// Byte queue between the muxed TFT producers (init / scene / player) and the
// tft_spi serialiser. A producer can burst up to DEPTH bytes without waiting
// on SPI shifting. Each entry holds an 8-bit byte plus its D/C flag, and the
// entries are issued to tft_spi one at a time with a transmit/busy handshake.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active low
//   in_data       producer byte
//   in_dc         producer D/C flag (0 = command, 1 = data)
//   in_transmit   producer strobe, one byte per high cycle
//   in_busy       registered back-pressure to the producer
//   spi_data      byte presented to tft_spi (held until the next pop)
//   spi_dc        D/C flag presented to tft_spi
//   spi_transmit  one-cycle start strobe to tft_spi
//   spi_busy      tft_spi busy
//   level         current entry count, 0..DEPTH
//   idle          queue empty and SPI link quiet
//   overflow      sticky, set when a strobe arrives while full
//
// Read FSM
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | ready to pop the head entry once spi_busy is low
//   S_WAIT_RISE | strobe issued; waiting up to TIMEOUT cycles for spi_busy
//   S_WAIT_FALL | serialiser accepted the byte; waiting for spi_busy to drop
// -----------------------------------------------------------------------------
module tft_byte_fifo #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_dc,
  input  logic                     in_transmit,
  output logic                     in_busy,
  output logic [7:0]               spi_data,
  output logic                     spi_dc,
  output logic                     spi_transmit,
  input  logic                     spi_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_WAIT_FALL
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      spi_data_q, spi_data_d;
  logic            spi_dc_q, spi_dc_d;
  logic            spi_tx_q, spi_tx_d;
  logic            in_busy_q, in_busy_d;
  logic            overflow_q, overflow_d;

  logic            full;
  logic            wr_en;
  logic            pop;

  // Fullness is judged on the pre-edge level, so a pop in the same cycle
  // does not make room for an incoming strobe.
  assign full  = (level_q == LVL_FULL);
  assign wr_en = in_transmit & ~full;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    spi_tx_d   = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && !spi_busy) begin
          pop      = 1'b1;
          spi_tx_d = 1'b1;
          timer_d  = '0;
          state_d  = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        // A serialiser that never raises busy still lets the queue drain.
        if (spi_busy) begin
          state_d = S_WAIT_FALL;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_FALL: begin
        if (!spi_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    level_d    = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    spi_data_d = spi_data_q;
    spi_dc_d   = spi_dc_q;
    if (pop) begin
      spi_data_d = mem_q[rd_ptr_q][7:0];
      spi_dc_d   = mem_q[rd_ptr_q][8];
    end
    // Busy for one cycle after every accepted write so a pulse producer
    // cannot push twice, and for as long as the queue is full.
    in_busy_d  = wr_en | (level_d == LVL_FULL);
    overflow_d = overflow_q | (in_transmit & full);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      timer_q    <= '0;
      spi_data_q <= '0;
      spi_dc_q   <= 1'b0;
      spi_tx_q   <= 1'b0;
      in_busy_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      spi_data_q <= spi_data_d;
      spi_dc_q   <= spi_dc_d;
      spi_tx_q   <= spi_tx_d;
      in_busy_q  <= in_busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {in_dc, in_data};
    end
  end

  assign in_busy      = in_busy_q;
  assign spi_data     = spi_data_q;
  assign spi_dc       = spi_dc_q;
  assign spi_transmit = spi_tx_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign idle         = (level_q == '0) && (state_q == S_IDLE) && !spi_tx_q && !spi_busy;

endmodule
